// File: rtl/stream_lockstep_miter.sv
// Lockstep miter comparing a gold and a gate stream through a skew FIFO.
// Masked per-bit compare with sticky status, counters and first-fail capture.
module stream_lockstep_miter #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      gold_valid,
  input  logic [CHANNELS*WIDTH-1:0] gold_data,
  input  logic [CHANNELS*WIDTH-1:0] gold_mask,
  input  logic                      gate_valid,
  input  logic [CHANNELS*WIDTH-1:0] gate_data,
  output logic                      mismatch,
  output logic [CHANNELS-1:0]       mismatch_chan,
  output logic                      err_sticky,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      halted,
  output logic [CNT_W-1:0]          cmp_count,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          first_index,
  output logic [CHANNELS-1:0]       first_chan,
  output logic [CHANNELS*WIDTH-1:0] first_gold,
  output logic [CHANNELS*WIDTH-1:0] first_gate
);

  localparam int BW = CHANNELS * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] mem_data [DEPTH];
  logic [BW-1:0] mem_mask [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  logic empty, full, active;
  logic push_req, push, pop;
  logic fail, ovf_evt, unf_evt;
  logic [BW-1:0] head_data, head_mask, diff;
  logic [CHANNELS-1:0] chan_fail;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign active   = (state_q == RUN) && en && !clear && !rst;
  assign push_req = active && gold_valid;
  assign pop      = active && gate_valid && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_evt  = push_req && full && !pop;
  assign unf_evt  = active && gate_valid && empty;

  assign head_data = mem_data[rd_ptr[AW-1:0]];
  assign head_mask = mem_mask[rd_ptr[AW-1:0]];
  assign diff      = (head_data ^ gate_data) & ~head_mask;
  assign fail      = pop && (|chan_fail);
  assign halted    = (state_q == HALT);

  // Reduce masked difference to one fail bit per channel
  always_comb begin
    chan_fail = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_fail[c] = |diff[c*WIDTH +: WIDTH];
    end
  end

  // Next-state logic; clear always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (!en) state_d = IDLE;
        else if (fail && STOP_ON_FAIL) state_d = HALT;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Skew FIFO pointers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Skew FIFO storage; gold sample and its mask travel together
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= gold_data;
      mem_mask[wr_ptr[AW-1:0]] <= gold_mask;
    end
  end

  // Compare results, sticky status, counters and first-fail capture
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mismatch      <= 1'b0;
      mismatch_chan <= '0;
      err_sticky    <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      cmp_count     <= '0;
      err_count     <= '0;
      first_index   <= '0;
      first_chan    <= '0;
      first_gold    <= '0;
      first_gate    <= '0;
    end else begin
      mismatch      <= fail;
      mismatch_chan <= fail ? chan_fail : '0;
      if (fail || ovf_evt || unf_evt) err_sticky <= 1'b1;
      if (ovf_evt) overflow  <= 1'b1;
      if (unf_evt) underflow <= 1'b1;
      if (pop) cmp_count <= cmp_count + CNT_ONE;
      if (fail && (err_count != '1)) err_count <= err_count + CNT_ONE;
      if (fail && !err_sticky) begin
        first_index <= cmp_count;
        first_chan  <= chan_fail;
        first_gold  <= head_data;
        first_gate  <= gate_data;
      end
    end
  end

endmodule
